// File: rtl/tetris_pkg.sv
// Shared types, constants and the spawn-shape ROM for the tetris playfield.
// Each shape is stored as a stack of board rows, with row 0 as the top row of the piece.
package tetris_pkg;

   localparam int         BOARD_ROWS = 8;
   localparam logic [7:0] FULL_ROW   = 8'hFF;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SPAWN,
      S_FALL,
      S_LOCK,
      S_SCAN,
      S_SHIFT,
      S_GAME_OVER
   } state_t;

   typedef enum logic [1:0] {
      P_O,
      P_I,
      P_L,
      P_T
   } piece_t;

   typedef logic [3:0][7:0]            rows_t;
   typedef logic [BOARD_ROWS-1:0][7:0] board_t;

   typedef struct packed {
      rows_t      rows;
      logic [2:0] h;
   } shape_t;

   function automatic shape_t shape_rom(input piece_t p);
      shape_t s;
      s.rows = '0;
      s.h    = 3'd1;
      case (p)
         P_O: begin s.rows[0] = 8'h18; s.rows[1] = 8'h18; s.h = 3'd2; end
         P_I: begin s.rows[0] = 8'h3C; s.h = 3'd1; end
         P_L: begin s.rows[0] = 8'h10; s.rows[1] = 8'h10; s.rows[2] = 8'h18; s.h = 3'd3; end
         P_T: begin s.rows[0] = 8'h38; s.rows[1] = 8'h10; s.h = 3'd2; end
      endcase
      return s;
   endfunction

endpackage

// File: rtl/tetris_playfield_collide.sv
// Combinational overlap test between a candidate piece placement and the locked board.
// Piece rows that would land below board row 0 are skipped; callers never offer such a placement.
module piece_collide
   import tetris_pkg::*;
(
   input  logic [BOARD_ROWS-1:0][7:0] i_board,
   input  logic [3:0][7:0]            i_rows,
   input  logic [2:0]                 i_py,
   input  logic [2:0]                 i_h,
   output logic                       o_hit
);

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      o_hit = 1'b0;
      for (int r = 0; r < 4; r++) begin
         if (3'(r) < i_h && 3'(r) <= i_py)
            o_hit = o_hit | (|(i_board[i_py - 3'(r)] & i_rows[r]));
      end
   end

endmodule

// File: rtl/tetris_playfield.sv
// Tetris game state: the locked board drives red_array and the falling piece drives green_array.
// It handles gravity and moves, locks pieces, clears full rows bottom-up, and detects game over.
module tetris_playfield
   import tetris_pkg::*;
#(
   parameter int SPAWN_ROW = 7,
   parameter int LINES_W   = 8
)(
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       start,
   input  logic                       tick,
   input  logic                       move_left,
   input  logic                       move_right,
   input  logic [1:0]                 next_piece,
   output logic [BOARD_ROWS-1:0][7:0] red_array,
   output logic [BOARD_ROWS-1:0][7:0] green_array,
   output logic                       game_over,
   output logic [LINES_W-1:0]         lines_cleared
);

   localparam logic [2:0] SPAWN_PY = 3'(SPAWN_ROW);

   state_t             r_state, w_next_state;
   board_t             r_board;
   rows_t              r_rows;
   logic [2:0]         r_h, r_py, r_k;
   logic [LINES_W-1:0] r_lines;

   shape_t     w_shape;
   rows_t      w_down_rows, w_left_rows, w_right_rows;
   logic [2:0] w_down_py, w_down_h;
   logic       w_hit_down, w_hit_left, w_hit_right;
   logic       w_edge_left, w_edge_right;
   logic       w_in_fall, w_can_fall, w_do_fall, w_do_left, w_do_right, w_row_full;

   // In SPAWN the down checker is reused to test the new shape at the spawn row.
   always_comb begin
      w_shape      = shape_rom(piece_t'(next_piece));
      w_left_rows  = '0;
      w_right_rows = '0;
      w_edge_left  = 1'b0;
      w_edge_right = 1'b0;
      for (int r = 0; r < 4; r++) begin
         w_left_rows[r]  = r_rows[r] << 1;
         w_right_rows[r] = r_rows[r] >> 1;
         w_edge_left     = w_edge_left  | r_rows[r][7];
         w_edge_right    = w_edge_right | r_rows[r][0];
      end
      if (r_state == S_SPAWN) begin
         w_down_rows = w_shape.rows;
         w_down_py   = SPAWN_PY;
         w_down_h    = w_shape.h;
      end else begin
         w_down_rows = r_rows;
         w_down_py   = r_py - 3'd1;
         w_down_h    = r_h;
      end
      w_in_fall  = (r_state == S_FALL);
      w_can_fall = (r_py >= r_h) && !w_hit_down;
      w_do_fall  = w_in_fall && tick && w_can_fall;
      w_do_left  = w_in_fall && !tick && move_left && !move_right && !w_edge_left && !w_hit_left;
      w_do_right = w_in_fall && !tick && move_right && !move_left && !w_edge_right && !w_hit_right;
      w_row_full = (r_board[r_k] == FULL_ROW);
   end

   piece_collide u_collide_down (
      .i_board (r_board),
      .i_rows  (w_down_rows),
      .i_py    (w_down_py),
      .i_h     (w_down_h),
      .o_hit   (w_hit_down)
   );

   piece_collide u_collide_left (
      .i_board (r_board),
      .i_rows  (w_left_rows),
      .i_py    (r_py),
      .i_h     (r_h),
      .o_hit   (w_hit_left)
   );

   piece_collide u_collide_right (
      .i_board (r_board),
      .i_rows  (w_right_rows),
      .i_py    (r_py),
      .i_h     (r_h),
      .o_hit   (w_hit_right)
   );

   // NOTE: sequential state is written only with non-blocking assignments, so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      unique case (r_state)
         S_IDLE:      if (start) w_next_state = S_SPAWN;
         S_SPAWN:     w_next_state = w_hit_down ? S_GAME_OVER : S_FALL;
         S_FALL:      if (tick && !w_can_fall) w_next_state = S_LOCK;
         S_LOCK:      w_next_state = S_SCAN;
         S_SCAN: begin
            if (w_row_full)         w_next_state = S_SHIFT;
            else if (r_k == 3'd7)   w_next_state = S_SPAWN;
         end
         S_SHIFT:     w_next_state = S_SCAN;
         S_GAME_OVER: if (start) w_next_state = S_SPAWN;
         default:     w_next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_board <= '0;
         r_rows  <= '0;
         r_h     <= '0;
         r_py    <= SPAWN_PY;
         r_k     <= '0;
         r_lines <= '0;
      end else begin
         case (r_state)
            S_IDLE, S_GAME_OVER: begin
               if (start) begin
                  r_board <= '0;
                  r_lines <= '0;
               end
            end
            S_SPAWN: begin
               r_rows <= w_shape.rows;
               r_h    <= w_shape.h;
               r_py   <= SPAWN_PY;
            end
            S_FALL: begin
               if (w_do_fall)       r_py   <= r_py - 3'd1;
               else if (w_do_left)  r_rows <= w_left_rows;
               else if (w_do_right) r_rows <= w_right_rows;
            end
            S_LOCK: begin
               for (int r = 0; r < 4; r++) begin
                  if (3'(r) < r_h && 3'(r) <= r_py)
                     r_board[r_py - 3'(r)] <= r_board[r_py - 3'(r)] | r_rows[r];
               end
               r_rows <= '0;
               r_k    <= '0;
            end
            S_SCAN: begin
               if (!w_row_full && r_k != 3'd7) r_k <= r_k + 3'd1;
            end
            S_SHIFT: begin
               for (int j = 0; j < BOARD_ROWS - 1; j++) begin
                  if (3'(j) >= r_k) r_board[j] <= r_board[3'(j + 1)];
               end
               r_board[BOARD_ROWS-1] <= '0;
               if (r_lines != {LINES_W{1'b1}}) r_lines <= r_lines + LINES_W'(1);
            end
            default: ;
         endcase
      end
   end

   // The piece overlay is hidden whenever no game is in progress.
   always_comb begin
      green_array = '0;
      game_over   = (r_state == S_GAME_OVER);
      if (r_state != S_IDLE && r_state != S_GAME_OVER) begin
         for (int r = 0; r < 4; r++) begin
            if (3'(r) < r_h && 3'(r) <= r_py)
               green_array[r_py - 3'(r)] = r_rows[r];
         end
      end
   end

   assign red_array     = r_board;
   assign lines_cleared = r_lines;

endmodule

// File: doc/tetris_playfield.md
Name: tetris_playfield

Overview:
- Game-state stage directly upstream of led_matrix_driver; produces its red_array and green_array (8x8, row 7 = top, bit 7 = leftmost column).
- Holds the locked-cell board (shown red) and one falling piece (shown green).
- Applies gravity ticks and left/right moves, locks pieces, clears full rows, and detects game over.
- Runs on the divided display-domain clock; tick, move and start inputs arrive as single-cycle pulses.

Parameters:
SPAWN_ROW, 7, board row that receives piece row 0 (top) at spawn.
LINES_W, 8, width of lines_cleared counter.

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset (0 = reset)
start  input  1  pulse; begins a game from IDLE or GAME_OVER
tick  input  1  gravity pulse; piece falls one row
move_left  input  1  pulse; shift piece one column left
move_right  input  1  pulse; shift piece one column right
next_piece  input  2  shape sampled in SPAWN: 0=O, 1=I, 2=L, 3=T
red_array  output  [7:0][7:0]  locked board, registered
green_array  output  [7:0][7:0]  active-piece overlay
game_over  output  1  high while in GAME_OVER
lines_cleared  output  LINES_W  rows cleared this game, saturating

Behaviour:
- Reset (reset=0, async): state=IDLE, board=0, piece=0, py=SPAWN_ROW, lines_cleared=0, game_over=0. Outputs red_array=0 and green_array=0.
- Piece model: piece_rows[3:0][7:0] holds positioned rows (r=0 top); height h from shape ROM; py = board row of piece row 0. Piece row r occupies board row py-r for r<h.
- Spawn shapes, top to bottom:
  - O = 00011000,00011000 (h=2)
  - I = 00111100 (h=1)
  - L = 00010000,00010000,00011000 (h=3)
  - T = 00111000,00010000 (h=2)
- green_array[py-r] = piece_rows[r] for r<h, all other rows 0. green_array is 0 in IDLE and GAME_OVER. Derived combinationally from registers only.
- States: IDLE, SPAWN, FALL, LOCK, SCAN, SHIFT, GAME_OVER.
- IDLE: on start, clear board and lines_cleared, go to SPAWN.
- SPAWN (1 cycle): load shape for next_piece and set py=SPAWN_ROW.
  - Spawned piece overlaps board -> GAME_OVER; the colliding piece is not merged.
  - Otherwise -> FALL.
- FALL, one action per cycle, with priority tick > moves:
  - tick:
    - If py-(h-1) > 0 and the piece shifted down one row does not collide: py-=1.
    - Otherwise -> LOCK.
    - Moves arriving in the same cycle as tick are dropped.
  - move_left alone: allowed only if no row has bit7 set and the left-shifted piece does not collide; else no change.
  - move_right alone: same rule with bit0 and a right shift.
  - move_left and move_right together: both ignored.
- LOCK (1 cycle): board[py-r] |= piece_rows[r]; set scan row k=0; -> SCAN.
- SCAN (1 cycle per row, bottom-up):
  - board[k]==8'hFF -> SHIFT.
  - Otherwise k+=1; after checking k=7 -> SPAWN.
- SHIFT (1 cycle):
  - board[j]=board[j+1] for j=k..6; board[7]=0.
  - lines_cleared+=1, saturating at 2^LINES_W-1.
  - -> SCAN with the same k, so stacked full rows are caught.
- GAME_OVER: game_over=1, board frozen on red_array; start -> clear board and lines_cleared, -> SPAWN.
- start is ignored in SPAWN/FALL/LOCK/SCAN/SHIFT.
- tick and moves are ignored outside FALL.
- Reset asserted mid-SHIFT or at any other point returns immediately to reset values; no partial row state survives.
- Latency:
  - Move or tick to updated green_array: 1 clk.
  - Lock with no full rows to next spawn visible: 1 (LOCK) + 8 (SCAN) + 1 (SPAWN) clks.
  - Each cleared row adds 2 clks.

Decomposition:
- Package tetris_pkg:
  - state_t enum
  - piece_t enum (O, I, L, T)
  - shape ROM function returning rows[3:0][7:0] and height
  - constants BOARD_ROWS=8, FULL_ROW=8'hFF
- One sub-module, piece_collide: combinational; inputs board, candidate piece_rows, candidate py, h; output hit. Instantiated three times: down, left and right candidates.

Test Plan:
- Reset held low mid-game, then released -> red_array=0, green_array=0, lines_cleared=0, state IDLE. start with next_piece=0 -> green rows 7,6 = 8'h18.
- O piece with 6 ticks -> piece reaches rows 1,0. 7th tick -> red rows 1,0 = 8'h18, green clears, new piece appears at rows 7/6 after 10 clks.
- I piece with 4 move_left pulses -> 2 pulses shift it to 8'hF0, then blocked. 5 move_right from 8'hF0 -> stops at 8'h0F. move_left+move_right in the same cycle -> no change.
- Preload bottom row 8'hC3 via prior drops, then drop I at 8'h3C -> row 0 clears, rows above shift down, lines_cleared=1.
- Two simultaneous full rows (rows 0,1) completed by O -> two SHIFT cycles, lines_cleared=2, red rows 0,1 hold former rows 2,3.
- Stack pieces until a spawn overlaps -> game_over=1, green_array=0, red frozen. start -> board clears, game_over=0, new piece spawned.
